// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-cache, D-cache and memory-side signals of the
// shared-memory arbiter.
//   slave  : arbiter view (takes cache requests and memory returns; drives
//            grants, return strobes and the memory command bus)
//   master : environment view (caches and memory model)
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_grant;
  logic [15:0] i_data;
  logic        i_valid;

  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_grant;
  logic [15:0] d_data;
  logic        d_valid;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_data_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    output i_grant, i_data, i_valid, d_grant, d_data, d_valid,
           mem_addr, mem_wdata, mem_enable, mem_wr
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    input  i_grant, i_data, i_valid, d_grant, d_data, d_valid,
           mem_addr, mem_wdata, mem_enable, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port ownership arbiter between the I-cache and D-cache
// controllers and a single-port, fixed-latency main memory.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_arbiter_if.slave -- cache request/grant/return signals and the
//          memory command/return bus
// An owner keeps the memory for as long as it holds its request; each granted
// high cycle issues one access. After release, the arbiter waits in DRAIN
// until every outstanding read has returned, so returns are always routed to
// the port that issued them.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_issue;
  logic          ret;

  // A return only counts while reads are outstanding; anything else (stray
  // pulses, data in flight across a reset) is dropped.
  assign ret         = bus.mem_data_valid && (cnt_q != '0);
  assign bus.i_valid = ret && (owner_q == SEL_I);
  assign bus.d_valid = ret && (owner_q == SEL_D);
  assign bus.i_data  = bus.mem_rdata;
  assign bus.d_data  = bus.mem_rdata;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    bus.i_grant    = 1'b0;
    bus.d_grant    = 1'b0;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    rd_issue       = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the port that did not own last wins.
        if (bus.i_req && bus.d_req) begin
          if (last_owner_q == SEL_D) begin
            state_d = OWN_I;
            owner_d = SEL_I;
          end else begin
            state_d = OWN_D;
            owner_d = SEL_D;
          end
        end else if (bus.i_req) begin
          state_d = OWN_I;
          owner_d = SEL_I;
        end else if (bus.d_req) begin
          state_d = OWN_D;
          owner_d = SEL_D;
        end
      end
      OWN_I: begin
        bus.i_grant = 1'b1;
        if (bus.i_req) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = bus.i_addr;
          rd_issue       = 1'b1;
        end else begin
          state_d      = DRAIN;
          last_owner_d = SEL_I;
        end
      end
      OWN_D: begin
        bus.d_grant = 1'b1;
        if (bus.d_req) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = bus.d_addr;
          bus.mem_wr     = bus.d_wr;
          bus.mem_wdata  = bus.d_wdata;
          rd_issue       = !bus.d_wr;
        end else begin
          state_d      = DRAIN;
          last_owner_d = SEL_D;
        end
      end
      DRAIN: begin
        // Leave as soon as the final outstanding read is being returned.
        if (cnt_q == '0 || (cnt_q == CW'(1) && ret)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({rd_issue, ret})
      2'b10:   if (cnt_q != CW'(MEM_LATENCY)) cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= SEL_I;
      last_owner_q <= SEL_I;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter between the instruction-cache and data-cache controllers and the shared single-port `memory4c` main memory. Each cache controller's fill/write-through logic requests ownership, holds it for a whole burst (e.g. an 8-word line fill), and receives returned read words on its own valid strobe. Read returns are tracked across the memory's fixed pipeline latency, so ownership is never handed over while read data is still in flight.

## Interface
- `MEM_LATENCY`, 4: cycles from a read issue to its `mem_data_valid`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  I-cache requests ownership; held high for the whole burst; each granted high cycle is one read.
- `i_addr`  in  16  I-cache read address, valid while `i_req`.
- `i_grant`  out  1  I-cache owns memory.
- `i_data`  out  16  read data to I-cache (= `mem_rdata`).
- `i_valid`  out  1  `i_data` valid this cycle.
- `d_req`  in  1  D-cache requests ownership; each granted high cycle is one access.
- `d_wr`  in  1  D-cache access is a write.
- `d_addr`  in  16  D-cache address.
- `d_wdata`  in  16  D-cache write data.
- `d_grant`  out  1  D-cache owns memory.
- `d_data`  out  16  read data to D-cache (= `mem_rdata`).
- `d_valid`  out  1  `d_data` valid this cycle.
- `mem_addr`  out  16  to memory `addr`.
- `mem_wdata`  out  16  to memory `data_in`.
- `mem_enable`  out  1  to memory `enable`.
- `mem_wr`  out  1  to memory `wr`.
- `mem_rdata`  in  16  from memory `data_out`.
- `mem_data_valid`  in  1  from memory `data_valid`.

## Operation
- States: IDLE, OWN_I, OWN_D, DRAIN. Registers: `owner` (I/D), `last_owner` (reset I), outstanding-read counter `cnt` (width clog2(MEM_LATENCY+1)).
- IDLE:
  - Only one request high: next state is OWN of that requester.
  - Both high: grant the port that is not `last_owner`. After reset, D wins first.
- OWN_x:
  - `x_grant`=1.
  - `x_req`=1: issue an access. `mem_enable`=1, `mem_addr`=`x_addr`.
  - For D: `mem_wr`=`d_wr`, `mem_wdata`=`d_wdata`. For I: `mem_wr`=0.
  - A read issue increments `cnt`. Writes never touch `cnt`.
  - `x_req`=0: no access this cycle. Next state is DRAIN; `last_owner`←x.
  - The non-owner's request is ignored until IDLE.
- DRAIN:
  - No issues. `mem_enable`=0, grants 0.
  - Returns are still routed to `owner`.
  - Next state is IDLE when `cnt`==0, or when `cnt`==1 and `mem_data_valid`=1.
- Return routing:
  - `x_valid` = `mem_data_valid` & `cnt`≠0 & `owner`==x.
  - Every valid return decrements `cnt`.
  - An increment and a decrement in the same cycle leave `cnt` unchanged.
- Stray `mem_data_valid` with `cnt`==0 is dropped: no valid strobe, `cnt` stays 0.
- Outputs when no access is issued: `mem_addr`=0, `mem_wdata`=0, `mem_wr`=0, `mem_enable`=0.
- `cnt` saturates at MEM_LATENCY. A well-formed owner never exceeds it.

## Timing
- All outputs after reset: grants 0, valids 0, `mem_*` 0, `i_data`/`d_data` follow `mem_rdata`.
- Reset in any state: IDLE, `cnt`=0, `last_owner`=I, on the next edge. Data returning after reset is dropped.
- Grant is registered. A request seen in IDLE at cycle t gives grant high at t+1. The first access issues at t+1.
- A read issued at cycle k returns at k+MEM_LATENCY. `x_valid` is combinational from `mem_data_valid` in that same cycle.
- Request falls at cycle r: no issue at r; grant low from r+1 (DRAIN).
- Minimum turnaround: a write-only burst ending at r reaches IDLE at r+2. The other port's grant is high at r+3.

## Test plan
- I fill: `i_req`=1 cycles 0–8 (low at 9), `i_addr`=0x0040,0x0042..0x004E on cycles 1–8 -> `i_grant` cycles 1–9, `mem_enable` cycles 1–8, `i_valid` cycles 5–12 with data from 0x0040..0x004E in order, DRAIN 10–12, IDLE 13, `d_valid` never high.
- Simultaneous `i_req`/`d_req` right after reset -> `d_grant` at cycle 1, `i_grant` stays 0. When D releases and drains, I is granted. A repeat simultaneous request then goes to D only after I finishes.
- D write: `d_req`=`d_wr`=1 for one cycle, `d_addr`=0x1230, `d_wdata`=0xBEEF -> `mem_wr`=1, `mem_addr`=0x1230, `mem_wdata`=0xBEEF during grant. `cnt` stays 0, no `d_valid`, IDLE two cycles after `d_req` falls.
- Reset asserted at cycle 3 of an 8-read I burst -> cycle 4: all grants 0, `mem_enable` 0, IDLE. The data_valid pulses that follow produce no `i_valid`/`d_valid`.
- Stray `mem_data_valid`=1 while IDLE -> no valid strobe, `cnt` stays 0.
- D mixed burst (write, read, read) -> exactly 2 `d_valid` pulses at issue+4. DRAIN lasts until the second pulse, then IDLE.
